// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: request/address out, data/ready strobe back.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_readM;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_inputReady;

  modport master (
    output mem_readM,
    output mem_address,
    input  mem_data,
    input  mem_inputReady
  );

  modport slave (
    input  mem_readM,
    input  mem_address,
    output mem_data,
    output mem_inputReady
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues one instruction read per fetch_start, latches the word,
// and returns next_PC/PCwrite; redirects squash any in-flight fetch.
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                fetch_start,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_PC,
  instr_fetch_unit_if.master  mem,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   next_PC,
  output logic                PCwrite,
  output logic                busy,
  output logic                fetch_err
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_readM_q, mem_readM_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0] next_PC_q, next_PC_d;
  logic              PCwrite_q, PCwrite_d;
  logic              fetch_err_q, fetch_err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [TW-1:0]     timer_inc;
  logic              timeout_hit;

  // Timer saturates; the >= compare still fires if a redirect pushed it past the limit.
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (timer_q >= TLIM);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    mem_address_d = mem_address_q;
    mem_readM_d   = mem_readM_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    next_PC_d     = next_PC_q;
    PCwrite_d     = 1'b0;
    fetch_err_d   = fetch_err_q;
    timer_d       = timer_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          next_PC_d = redirect_PC;
          PCwrite_d = 1'b1;
        end else if (fetch_start) begin
          fetch_pc_d    = PC;
          mem_address_d = PC;
          mem_readM_d   = 1'b1;
          timer_d       = '0;
          state_d       = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          next_PC_d   = redirect_PC;
          PCwrite_d   = 1'b1;
          mem_readM_d = 1'b0;
          timer_d     = timer_inc;
          state_d     = mem.mem_inputReady ? IDLE : FLUSH;
        end else if (mem.mem_inputReady) begin
          instr_d       = mem.mem_data;
          instr_valid_d = 1'b1;
          next_PC_d     = fetch_pc_q + ADDR_W'(1);
          PCwrite_d     = 1'b1;
          mem_readM_d   = 1'b0;
          state_d       = IDLE;
        end else if (timeout_hit) begin
          fetch_err_d = 1'b1;
          mem_readM_d = 1'b0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      FLUSH: begin
        if (redirect) begin
          next_PC_d = redirect_PC;
          PCwrite_d = 1'b1;
        end
        if (mem.mem_inputReady) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      mem_address_q <= '0;
      mem_readM_q   <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      next_PC_q     <= '0;
      PCwrite_q     <= 1'b0;
      fetch_err_q   <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      mem_address_q <= mem_address_d;
      mem_readM_q   <= mem_readM_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      next_PC_q     <= next_PC_d;
      PCwrite_q     <= PCwrite_d;
      fetch_err_q   <= fetch_err_d;
      timer_q       <= timer_d;
    end
  end

  assign mem.mem_readM   = mem_readM_q;
  assign mem.mem_address = mem_address_q;
  assign instr           = instr_q;
  assign instr_valid     = instr_valid_q;
  assign next_PC         = next_PC_q;
  assign PCwrite         = PCwrite_q;
  assign busy            = (state_q != IDLE);
  assign fetch_err       = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a transaction-level reference model.
module tb_instr_fetch_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] PC = '0;
  logic        fetch_start = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_PC = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] next_PC;
  logic        PCwrite;
  logic        busy;
  logic        fetch_err;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .PC          (PC),
    .fetch_start (fetch_start),
    .redirect    (redirect),
    .redirect_PC (redirect_PC),
    .mem         (mem_if.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .next_PC     (next_PC),
    .PCwrite     (PCwrite),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding read request, optionally squashed,
  // with an age counting unanswered cycles since it was issued.
  bit          outstanding = 0;
  bit          squashed    = 0;
  int          age         = 0;
  logic [15:0] req_pc      = '0;
  logic        e_readM = 0, e_iv = 0, e_pcw = 0, e_err = 0;
  logic [15:0] e_addr = '0, e_instr = '0, e_npc = '0;

  always @(posedge clk) begin
    e_iv  = 0;
    e_pcw = 0;
    if (!reset_n) begin
      outstanding = 0; squashed = 0; age = 0; req_pc = '0;
      e_readM = 0; e_err = 0; e_addr = '0; e_instr = '0; e_npc = '0;
    end else if (!outstanding) begin
      if (redirect) begin
        e_npc = redirect_PC; e_pcw = 1;
      end else if (fetch_start) begin
        outstanding = 1; squashed = 0; age = 0; req_pc = PC;
        e_readM = 1; e_addr = PC;
      end
    end else if (!squashed) begin
      if (redirect) begin
        e_npc = redirect_PC; e_pcw = 1; e_readM = 0;
        if (mem_if.mem_inputReady) outstanding = 0;
        else begin squashed = 1; age++; end
      end else if (mem_if.mem_inputReady) begin
        e_instr = mem_if.mem_data; e_iv = 1;
        e_npc = req_pc + 16'd1; e_pcw = 1; e_readM = 0; outstanding = 0;
      end else if (age >= TO - 1) begin
        e_err = 1; e_readM = 0; outstanding = 0;
      end else age++;
    end else begin
      if (redirect) begin e_npc = redirect_PC; e_pcw = 1; end
      if (mem_if.mem_inputReady) outstanding = 0;
      else if (age >= TO - 1) begin e_err = 1; outstanding = 0; end
      else age++;
    end
  end

  always @(negedge clk) begin
    chk("m_readM", mem_if.mem_readM, e_readM);
    chk("m_addr", mem_if.mem_address, e_addr);
    chk("m_instr", instr, e_instr);
    chk("m_ivalid", instr_valid, e_iv);
    chk("m_nextpc", next_PC, e_npc);
    chk("m_pcwrite", PCwrite, e_pcw);
    chk("m_busy", busy, outstanding);
    chk("m_err", fetch_err, e_err);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    mem_if.mem_data       = '0;
    mem_if.mem_inputReady = 1'b0;
    repeat (2) tick();
    chk("rst_readM", mem_if.mem_readM, 0);
    chk("rst_instr", instr, 0);
    chk("rst_nextpc", next_PC, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    tick();

    // 1 basic fetch, response on c3
    PC = 16'h0010; fetch_start = 1;
    tick(); fetch_start = 0;
    chk("t1_readM_c1", mem_if.mem_readM, 1);
    chk("t1_addr_c1", mem_if.mem_address, 16'h0010);
    chk("t1_busy_c1", busy, 1);
    tick();
    tick(); mem_if.mem_inputReady = 1; mem_if.mem_data = 16'hA5C3;
    tick(); mem_if.mem_inputReady = 0;
    chk("t1_instr", instr, 16'hA5C3);
    chk("t1_ivalid", instr_valid, 1);
    chk("t1_nextpc", next_PC, 16'h0011);
    chk("t1_pcwrite", PCwrite, 1);
    chk("t1_readM_c4", mem_if.mem_readM, 0);
    tick();
    chk("t1_ivalid_c5", instr_valid, 0);
    chk("t1_pcwrite_c5", PCwrite, 0);

    // 2 wrap, minimum latency response
    PC = 16'hFFFF; fetch_start = 1;
    tick(); fetch_start = 0; mem_if.mem_inputReady = 1; mem_if.mem_data = 16'h1234;
    tick(); mem_if.mem_inputReady = 0;
    chk("t2_nextpc", next_PC, 16'h0000);
    chk("t2_pcwrite", PCwrite, 1);
    chk("t2_instr", instr, 16'h1234);
    tick();

    // 3 squash: redirect c2, stale response c4
    PC = 16'h0020; fetch_start = 1;
    tick(); fetch_start = 0;
    tick(); redirect = 1; redirect_PC = 16'h0100;
    tick(); redirect = 0;
    chk("t3_pcwrite", PCwrite, 1);
    chk("t3_nextpc", next_PC, 16'h0100);
    chk("t3_busy_c3", busy, 1);
    tick(); mem_if.mem_inputReady = 1; mem_if.mem_data = 16'hDEAD;
    tick(); mem_if.mem_inputReady = 0;
    chk("t3_ivalid", instr_valid, 0);
    chk("t3_instr", instr, 16'h1234);
    chk("t3_busy_c5", busy, 0);

    // 4 redirect and response in the same WAIT cycle
    PC = 16'h0030; fetch_start = 1;
    tick(); fetch_start = 0; redirect = 1; redirect_PC = 16'h0200;
    mem_if.mem_inputReady = 1; mem_if.mem_data = 16'hBEEF;
    tick(); redirect = 0; mem_if.mem_inputReady = 0;
    chk("t4_nextpc", next_PC, 16'h0200);
    chk("t4_ivalid", instr_valid, 0);
    chk("t4_instr", instr, 16'h1234);
    chk("t4_busy", busy, 0);

    // redirect in IDLE wins over fetch_start
    PC = 16'h0050; fetch_start = 1; redirect = 1; redirect_PC = 16'h0300;
    tick(); fetch_start = 0; redirect = 0;
    chk("idle_redir_pc", next_PC, 16'h0300);
    chk("idle_redir_readM", mem_if.mem_readM, 0);

    // 5 timeout after TO unanswered WAIT cycles
    PC = 16'h0060; fetch_start = 1;
    tick(); fetch_start = 0;
    repeat (7) tick();
    chk("t5_err_c8", fetch_err, 0);
    chk("t5_readM_c8", mem_if.mem_readM, 1);
    tick();
    chk("t5_err_c9", fetch_err, 1);
    chk("t5_readM_c9", mem_if.mem_readM, 0);
    PC = 16'h0070; fetch_start = 1;
    tick(); fetch_start = 0; mem_if.mem_inputReady = 1; mem_if.mem_data = 16'h4242;
    tick(); mem_if.mem_inputReady = 0;
    chk("t5_err_sticky", fetch_err, 1);
    chk("t5_nextpc", next_PC, 16'h0071);

    // 6 reset mid-WAIT, then a late response
    PC = 16'h0040; fetch_start = 1;
    tick(); fetch_start = 0;
    tick(); reset_n = 0;
    tick(); reset_n = 1; mem_if.mem_inputReady = 1; mem_if.mem_data = 16'h7777;
    chk("t6_err", fetch_err, 0);
    tick(); mem_if.mem_inputReady = 0;
    chk("t6_ivalid", instr_valid, 0);
    chk("t6_pcwrite", PCwrite, 0);
    chk("t6_instr", instr, 0);
    chk("t6_busy", busy, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
